// File: rtl/module_mux_n_1_rr.sv
// N-channel to 1 registered mux with fixed-select or round-robin arbitration and valid/ready output.
// Optional MUX_CHAN_ID_EN adds chan_o, the registered index of the captured channel.
module module_mux_n_1_rr #(
    parameter int BUS_WIDTH = 16,
    parameter int N_CH      = 4,
    localparam int CW       = $clog2(N_CH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_CH*BUS_WIDTH-1:0] data_i,
    input  logic [N_CH-1:0]           valid_i,
    input  logic [CW-1:0]             sel_i,
    input  logic                      mode_i,
    input  logic                      ready_i,
    output logic [BUS_WIDTH-1:0]      data_o,
    output logic                      valid_o,
    output logic [N_CH-1:0]           grant_o
`ifdef MUX_CHAN_ID_EN
    ,
    output logic [CW-1:0]             chan_o
`endif
);

    logic [BUS_WIDTH-1:0] data_p1;
    logic                 vld_p1;
    logic [N_CH-1:0]      grant_p1;
    logic [CW-1:0]        ptr;
`ifdef MUX_CHAN_ID_EN
    logic [CW-1:0]        chan_p1;
`endif

    logic                 cap_en;
    logic [N_CH-1:0]      rot;
    logic [CW-1:0]        rr_off;
    logic [CW:0]          rr_sum;
    logic                 pick_vld;
    logic [CW-1:0]        pick_idx;
    logic [BUS_WIDTH-1:0] pick_data;
    logic [CW-1:0]        ptr_next;

    // Stage p0: channel selection (combinational, inputs are not registered)
    always_comb begin
        cap_en    = !vld_p1 || ready_i;
        rot       = N_CH'({valid_i, valid_i} >> ptr);
        rr_off    = '0;
        rr_sum    = '0;
        pick_vld  = 1'b0;
        pick_idx  = '0;
        pick_data = '0;
        ptr_next  = ptr;

        if (mode_i) begin
            // Rotated view puts ptr at bit 0; the lowest set bit is the next channel in turn.
            for (int k = N_CH - 1; k >= 0; k--) begin
                if (rot[k]) rr_off = CW'(k);
            end
            rr_sum   = {1'b0, ptr} + {1'b0, rr_off};
            pick_vld = |valid_i;
            pick_idx = CW'((rr_sum >= (CW+1)'(N_CH)) ? rr_sum - (CW+1)'(N_CH) : rr_sum);
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (sel_i == CW'(k) && valid_i[k]) pick_vld = 1'b1;
            end
            pick_idx = sel_i;
        end

        for (int k = 0; k < N_CH; k++) begin
            if (pick_idx == CW'(k)) pick_data = data_i[k*BUS_WIDTH +: BUS_WIDTH];
        end

        ptr_next = (pick_idx == CW'(N_CH - 1)) ? '0 : pick_idx + 1'b1;
    end

    // Stage p1: output register and handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_p1  <= '0;
            vld_p1   <= 1'b0;
            grant_p1 <= '0;
            ptr      <= '0;
`ifdef MUX_CHAN_ID_EN
            chan_p1  <= '0;
`endif
        end else begin
            grant_p1 <= '0;
            if (cap_en) begin
                if (pick_vld) begin
                    data_p1  <= pick_data;
                    vld_p1   <= 1'b1;
                    grant_p1 <= {{(N_CH-1){1'b0}}, 1'b1} << pick_idx;
`ifdef MUX_CHAN_ID_EN
                    chan_p1  <= pick_idx;
`endif
                    if (mode_i) ptr <= ptr_next;
                end else begin
                    vld_p1 <= 1'b0;
                end
            end
        end
    end

    assign data_o  = data_p1;
    assign valid_o = vld_p1;
    assign grant_o = grant_p1;
`ifdef MUX_CHAN_ID_EN
    assign chan_o  = chan_p1;
`endif

endmodule

// File: tb/tb_module_mux_n_1_rr.sv
// Directed self-checking bench for module_mux_n_1_rr (BUS_WIDTH=16, N_CH=4).
module tb_module_mux_n_1_rr;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [63:0] data_i;
    logic [3:0]  valid_i;
    logic [1:0]  sel_i;
    logic        mode_i;
    logic        ready_i;
    logic [15:0] data_o;
    logic        valid_o;
    logic [3:0]  grant_o;
`ifdef MUX_CHAN_ID_EN
    logic [1:0]  chan_o;
`endif

    int checks = 0;
    int errors = 0;

    module_mux_n_1_rr #(.BUS_WIDTH(16), .N_CH(4)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .sel_i   (sel_i),
        .mode_i  (mode_i),
        .ready_i (ready_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .grant_o (grant_o)
`ifdef MUX_CHAN_ID_EN
        ,
        .chan_o  (chan_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; mode_i = 1'b1; ready_i = 1'b1; sel_i = 2'd0;
        valid_i = 4'b1111;
        data_i = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({valid_o, data_o, grant_o} !== {1'b0, 16'h0000, 4'b0000}) begin
                errors++;
                $display("FAIL reset_state cycle %0d: valid=%b data=%h grant=%b, want valid=0 data=0000 grant=0000",
                         i, valid_o, data_o, grant_o);
            end
        end
`ifdef MUX_CHAN_ID_EN
        checks++;
        if (chan_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_chan: chan=%0d want 0", chan_o);
        end
`endif
        rst_i = 1'b0;
        step();
        checks++;
        if ({valid_o, data_o, grant_o} !== {1'b1, 16'h0000, 4'b0001}) begin
            errors++;
            $display("FAIL reset_first_grant: valid=%b data=%h grant=%b, want valid=1 data=0000 grant=0001",
                     valid_o, data_o, grant_o);
        end
    endtask

    task automatic test_fixed();
        mode_i = 1'b0; sel_i = 2'd2; ready_i = 1'b1;
        valid_i = 4'b0100;
        data_i = {16'h0003, 16'hBEEF, 16'h0001, 16'h0000};
        step();
        checks++;
        if ({valid_o, data_o, grant_o} !== {1'b1, 16'hBEEF, 4'b0100}) begin
            errors++;
            $display("FAIL fixed_capture: valid=%b data=%h grant=%b, want valid=1 data=beef grant=0100",
                     valid_o, data_o, grant_o);
        end
`ifdef MUX_CHAN_ID_EN
        checks++;
        if (chan_o !== 2'd2) begin
            errors++;
            $display("FAIL fixed_chan: chan=%0d want 2", chan_o);
        end
`endif
        sel_i = 2'd1;
        step();
        checks++;
        if ({valid_o, grant_o} !== {1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL fixed_drain: valid=%b grant=%b, want valid=0 grant=0000", valid_o, grant_o);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ch [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        mode_i = 1'b1; ready_i = 1'b1; valid_i = 4'b1111;
        data_i = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({valid_o, data_o, grant_o} !== {1'b1, {14'd0, exp_ch[i]}, 4'b0001 << exp_ch[i]}) begin
                errors++;
                $display("FAIL rr_sequence step %0d: valid=%b data=%h grant=%b, want valid=1 data=%h grant=%b",
                         i, valid_o, data_o, grant_o, {14'd0, exp_ch[i]}, 4'b0001 << exp_ch[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        mode_i = 1'b0; sel_i = 2'd0; ready_i = 1'b0; valid_i = 4'b0001;
        data_i = {16'h3333, 16'h2222, 16'h1111, 16'h1234};
        step();
        checks++;
        if ({valid_o, data_o, grant_o} !== {1'b1, 16'h1234, 4'b0001}) begin
            errors++;
            $display("FAIL bp_load: valid=%b data=%h grant=%b, want valid=1 data=1234 grant=0001",
                     valid_o, data_o, grant_o);
        end
        mode_i = 1'b1; valid_i = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({valid_o, data_o, grant_o} !== {1'b1, 16'h1234, 4'b0000}) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b data=%h grant=%b, want valid=1 data=1234 grant=0000",
                         i, valid_o, data_o, grant_o);
            end
        end
        ready_i = 1'b1;
        step();
        checks++;
        if ({valid_o, data_o, grant_o} !== {1'b1, 16'h1111, 4'b0010}) begin
            errors++;
            $display("FAIL bp_release: valid=%b data=%h grant=%b, want valid=1 data=1111 grant=0010",
                     valid_o, data_o, grant_o);
        end
        step();
        checks++;
        if ({valid_o, data_o, grant_o} !== {1'b1, 16'h3333, 4'b1000}) begin
            errors++;
            $display("FAIL bp_no_bubble: valid=%b data=%h grant=%b, want valid=1 data=3333 grant=1000",
                     valid_o, data_o, grant_o);
        end
    endtask

    task automatic test_sparse();
        // ptr is 0 here; one grant to ch0 moves it to 1.
        mode_i = 1'b1; ready_i = 1'b1; valid_i = 4'b0001;
        data_i = {16'h0003, 16'h0002, 16'h0001, 16'h0000};
        step();
        checks++;
        if ({valid_o, data_o, grant_o} !== {1'b1, 16'h0000, 4'b0001}) begin
            errors++;
            $display("FAIL sparse_setup: valid=%b data=%h grant=%b, want valid=1 data=0000 grant=0001",
                     valid_o, data_o, grant_o);
        end
        valid_i = 4'b1001;
        step();
        checks++;
        if ({data_o, grant_o} !== {16'h0003, 4'b1000}) begin
            errors++;
            $display("FAIL sparse_ch3: data=%h grant=%b, want data=0003 grant=1000", data_o, grant_o);
        end
        step();
        checks++;
        if ({data_o, grant_o} !== {16'h0000, 4'b0001}) begin
            errors++;
            $display("FAIL sparse_wrap_ch0: data=%h grant=%b, want data=0000 grant=0001", data_o, grant_o);
        end
        mode_i = 1'b0; sel_i = 2'd3;
        step();
        checks++;
        if ({data_o, grant_o} !== {16'h0003, 4'b1000}) begin
            errors++;
            $display("FAIL sparse_fixed_ch3: data=%h grant=%b, want data=0003 grant=1000", data_o, grant_o);
        end
        // ptr must still be 1, so a full request set goes to ch1.
        mode_i = 1'b1; valid_i = 4'b1111;
        step();
        checks++;
        if ({data_o, grant_o} !== {16'h0001, 4'b0010}) begin
            errors++;
            $display("FAIL sparse_ptr_kept: data=%h grant=%b, want data=0001 grant=0010", data_o, grant_o);
        end
    endtask

    task automatic test_reset_hold();
        ready_i = 1'b0; mode_i = 1'b1; valid_i = 4'b1111;
        data_i = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        step();
        checks++;
        if ({valid_o, data_o, grant_o} !== {1'b1, 16'h0001, 4'b0000}) begin
            errors++;
            $display("FAIL rh_hold: valid=%b data=%h grant=%b, want valid=1 data=0001 grant=0000",
                     valid_o, data_o, grant_o);
        end
        rst_i = 1'b1;
        step();
        checks++;
        if ({valid_o, data_o, grant_o} !== {1'b0, 16'h0000, 4'b0000}) begin
            errors++;
            $display("FAIL rh_reset: valid=%b data=%h grant=%b, want valid=0 data=0000 grant=0000",
                     valid_o, data_o, grant_o);
        end
`ifdef MUX_CHAN_ID_EN
        checks++;
        if (chan_o !== 2'd0) begin
            errors++;
            $display("FAIL rh_chan: chan=%0d want 0", chan_o);
        end
`endif
        rst_i = 1'b0;
        step();
        checks++;
        if ({valid_o, data_o, grant_o} !== {1'b1, 16'hA000, 4'b0001}) begin
            errors++;
            $display("FAIL rh_ptr_zero: valid=%b data=%h grant=%b, want valid=1 data=a000 grant=0001",
                     valid_o, data_o, grant_o);
        end
        step();
        checks++;
        if ({valid_o, data_o, grant_o} !== {1'b1, 16'hA000, 4'b0000}) begin
            errors++;
            $display("FAIL rh_pulse_once: valid=%b data=%h grant=%b, want valid=1 data=a000 grant=0000",
                     valid_o, data_o, grant_o);
        end
    endtask

    initial begin
        rst_i = 1'b1; data_i = '0; valid_i = '0; sel_i = '0; mode_i = 1'b0; ready_i = 1'b0;
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_sparse();
        test_reset_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
